// File: rtl/sat_updown_ctrl_pkg.sv
// rtl/sat_updown_ctrl_pkg.sv - shared types and default constants for the saturating up/down controller
//
// Holds the auto-repeat FSM state type and the default parameter values
// used by sat_updown_ctrl and btn_conditioner.
// Optional feature macro: SAT_AUTOREPEAT_EN (the state type is only used when it is defined).

package sat_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  localparam int DEF_WIDTH      = 3;
  localparam int DEF_STEP       = 1;
  localparam int DEF_DB_CYCLES  = 1000;
  localparam int DEF_RPT_DELAY  = 50000;
  localparam int DEF_RPT_PERIOD = 10000;

endpackage

// File: rtl/sat_updown_ctrl_if.sv
// rtl/sat_updown_ctrl_if.sv - button inputs and counter/flag outputs of the saturating up/down controller
//
// Signals:
//   btn_up, btn_dn : raw asynchronous active-high buttons (driven by master)
//   value          : registered counter value, WIDTH bits (driven by slave)
//   at_min, at_max : registered flags, value==0 / value==MAX_VAL
//   led_r, led_g   : led_r mirrors at_max, led_g mirrors at_min
// Modports: master (button source / observer), slave (controller).

interface sat_updown_ctrl_if #(
  parameter int WIDTH = 3
);

  logic             btn_up;
  logic             btn_dn;
  logic [WIDTH-1:0] value;
  logic             at_min;
  logic             at_max;
  logic             led_r;
  logic             led_g;

  modport master (
    output btn_up, btn_dn,
    input  value, at_min, at_max, led_r, led_g
  );

  modport slave (
    input  btn_up, btn_dn,
    output value, at_min, at_max, led_r, led_g
  );

endinterface

// File: rtl/sat_updown_ctrl_btn_conditioner.sv
// rtl/sat_updown_ctrl_btn_conditioner.sv - button synchroniser, debouncer, rise detector and optional auto-repeat
//
// Module btn_conditioner. Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   btn   : raw asynchronous button
//   pulse : registered one-clock pulse per accepted press (and per repeat)
// Optional feature macro: SAT_AUTOREPEAT_EN adds an IDLE/HOLD/REPEAT FSM.

module btn_conditioner
  import sat_ctrl_pkg::*;
#(
  parameter int DB_CYCLES  = DEF_DB_CYCLES
`ifdef SAT_AUTOREPEAT_EN
  , parameter int RPT_DELAY  = DEF_RPT_DELAY
  , parameter int RPT_PERIOD = DEF_RPT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);

  logic            sync1;
  logic            sync2;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic            db_rise;

  // The debounced level only flips after sync2 has disagreed with it for
  // DB_CYCLES clocks in a row; agreement at any point clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign db_rise = db_level & ~db_prev;

`ifdef SAT_AUTOREPEAT_EN

  localparam int TMR_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  rpt_state_t       state;
  logic [TMR_W-1:0] tmr;

  // The first pulse comes from the debounced rise itself; the timer then
  // counts held clocks to the first repeat and between later repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          tmr <= '0;
          if (db_rise) begin
            state <= HOLD;
            pulse <= 1'b1;
          end
        end
        HOLD: begin
          if (!db_level) begin
            state <= IDLE;
            tmr   <= '0;
          end else if (tmr == TMR_W'(RPT_DELAY - 1)) begin
            state <= REPEAT;
            pulse <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        REPEAT: begin
          if (!db_level) begin
            state <= IDLE;
            tmr   <= '0;
          end else if (tmr == TMR_W'(RPT_PERIOD - 1)) begin
            pulse <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

`else

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse <= 1'b0;
    end else begin
      pulse <= db_rise;
    end
  end

`endif

endmodule

// File: rtl/sat_updown_ctrl.sv
// rtl/sat_updown_ctrl.sv - debounced saturating up/down counter with min/max flags and LEDs
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : sat_updown_ctrl_if.slave (btn_up, btn_dn in; value, at_min, at_max, led_r, led_g out)
// Optional feature macro: SAT_AUTOREPEAT_EN enables per-button auto-repeat.

module sat_updown_ctrl
  import sat_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MAX_VAL    = 2**WIDTH - 1,
  parameter int STEP       = DEF_STEP,
  parameter int DB_CYCLES  = DEF_DB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  sat_updown_ctrl_if.slave   bus
);

  if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1 || STEP < 1 || STEP > MAX_VAL ||
      DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
    $error("sat_updown_ctrl: illegal parameter set");
  end

  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);

  logic             up_pulse;
  logic             dn_pulse;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_nxt;
  logic             at_min_q;
  logic             at_max_q;
  logic [WIDTH:0]   value_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;

  btn_conditioner #(
    .DB_CYCLES(DB_CYCLES)
`ifdef SAT_AUTOREPEAT_EN
    , .RPT_DELAY(RPT_DELAY)
    , .RPT_PERIOD(RPT_PERIOD)
`endif
  ) u_cond_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_up),
    .pulse (up_pulse)
  );

  btn_conditioner #(
    .DB_CYCLES(DB_CYCLES)
`ifdef SAT_AUTOREPEAT_EN
    , .RPT_DELAY(RPT_DELAY)
    , .RPT_PERIOD(RPT_PERIOD)
`endif
  ) u_cond_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_dn),
    .pulse (dn_pulse)
  );

  // One extra bit so value+STEP can be compared against MAX_VAL without wrapping.
  assign value_x = {1'b0, value_q};
  assign up_sum  = value_x + STEP_X;
  assign dn_diff = value_x - STEP_X;

  always_comb begin
    value_nxt = value_q;
    if (up_pulse && !dn_pulse) begin
      value_nxt = (up_sum > MAX_X) ? MAX_V : up_sum[WIDTH-1:0];
    end else if (dn_pulse && !up_pulse) begin
      value_nxt = (value_x >= STEP_X) ? dn_diff[WIDTH-1:0] : '0;
    end
  end

  // Flags come from the same next value, so they never lag the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      value_q  <= value_nxt;
      at_min_q <= (value_nxt == '0);
      at_max_q <= (value_nxt == MAX_V);
    end
  end

  assign bus.value  = value_q;
  assign bus.at_min = at_min_q;
  assign bus.at_max = at_max_q;
  assign bus.led_r  = at_max_q;
  assign bus.led_g  = at_min_q;

endmodule

// File: tb/tb_sat_updown_ctrl.sv
// tb/tb_sat_updown_ctrl.sv - scoreboard bench for sat_updown_ctrl (STEP=1 and STEP=2 instances)

module tb_sat_updown_ctrl;

  localparam int DB  = 4;
  localparam int MXV = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sat_updown_ctrl_if #(.WIDTH(3)) ifa ();
  sat_updown_ctrl_if #(.WIDTH(3)) ifb ();

  sat_updown_ctrl #(
    .WIDTH(3), .MAX_VAL(MXV), .STEP(1), .DB_CYCLES(DB), .RPT_DELAY(20), .RPT_PERIOD(5)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  sat_updown_ctrl #(
    .WIDTH(3), .MAX_VAL(MXV), .STEP(2), .DB_CYCLES(DB), .RPT_DELAY(20), .RPT_PERIOD(5)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    int cyc;
    int va;
    int vb;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   ma      = 0;
  int   mb      = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int va, input int vb);
    check_eq({tag, "_a_value"},  int'(ifa.value),  va);
    check_eq({tag, "_a_at_min"}, int'(ifa.at_min), int'(va == 0));
    check_eq({tag, "_a_at_max"}, int'(ifa.at_max), int'(va == MXV));
    check_eq({tag, "_a_led_g"},  int'(ifa.led_g),  int'(va == 0));
    check_eq({tag, "_a_led_r"},  int'(ifa.led_r),  int'(va == MXV));
    check_eq({tag, "_b_value"},  int'(ifb.value),  vb);
    check_eq({tag, "_b_at_min"}, int'(ifb.at_min), int'(vb == 0));
    check_eq({tag, "_b_at_max"}, int'(ifb.at_max), int'(vb == MXV));
  endtask

  function automatic int m_up(input int v, input int step);
    return (v + step > MXV) ? MXV : v + step;
  endfunction

  function automatic int m_dn(input int v, input int step);
    return (v >= step) ? v - step : 0;
  endfunction

  // Pulses seen k clocks into a clean hold (k=1 is the first edge sampling high).
  function automatic int hold_pulses(input int k);
    int p;
    p = (k >= DB + 4) ? 1 : 0;
`ifdef SAT_AUTOREPEAT_EN
    if (k >= DB + 24) p = p + 1 + (k - (DB + 24)) / 5;
`endif
    return p;
  endfunction

  task automatic push_exp(input int cyc, input int va, input int vb);
    exp_t e;
    e.cyc = cyc;
    e.va  = va;
    e.vb  = vb;
    sb.push_back(e);
  endtask

  task automatic set_btn(input logic u, input logic d);
    ifa.btn_up = u;
    ifb.btn_up = u;
    ifa.btn_dn = d;
    ifb.btn_dn = d;
  endtask

  // Steps n clocks from a negedge, comparing every scoreboard entry whose cycle comes due.
  task automatic run_cycles(input int n, input string tag);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == k) begin
        e = sb.pop_front();
        check_state(tag, e.va, e.vb);
      end
    end
    check_eq({tag, "_sb_left"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic release_btns(input string tag);
    set_btn(1'b0, 1'b0);
    push_exp(12, ma, mb);
    run_cycles(12, {tag, "_rel"});
  endtask

  task automatic press(input logic u, input logic d, input string tag);
    int oa, ob;
    oa = ma;
    ob = mb;
    if (u && !d) begin
      ma = m_up(ma, 1);
      mb = m_up(mb, 2);
    end else if (d && !u) begin
      ma = m_dn(ma, 1);
      mb = m_dn(mb, 2);
    end
    set_btn(u, d);
    push_exp(DB + 3, oa, ob);
    push_exp(DB + 4, ma, mb);
    run_cycles(DB + 6, tag);
    release_btns(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state(tag, 0, 0);
    rst = 1'b0;
    ma  = 0;
    mb  = 0;
  endtask

  task automatic hold_up(input int n, input string tag);
    int p;
    set_btn(1'b1, 1'b0);
    for (int k = 1; k <= n; k++) begin
      p = hold_pulses(k);
      push_exp(k, (p > MXV) ? MXV : p, (2 * p > MXV) ? MXV : 2 * p);
    end
    run_cycles(n, tag);
    p  = hold_pulses(n);
    ma = (p > MXV) ? MXV : p;
    mb = (2 * p > MXV) ? MXV : 2 * p;
  endtask

  initial begin
    set_btn(1'b0, 1'b0);
    @(negedge clk);
    do_reset("reset");

    for (int i = 0; i < 8; i++) press(1'b1, 1'b0, "up");
    for (int i = 0; i < 4; i++) press(1'b0, 1'b1, "dn");
    press(1'b1, 1'b1, "both");

    // Bounce: high 2, low 1, then a clean high for 10 clocks.
    set_btn(1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_btn(1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_btn(1'b1, 1'b0);
    push_exp(DB + 3, ma, mb);
    ma = m_up(ma, 1);
    mb = m_up(mb, 2);
    push_exp(DB + 4, ma, mb);
    push_exp(10, ma, mb);
    run_cycles(10, "bounce");
    release_btns("bounce");

    do_reset("reset2");
    press(1'b0, 1'b1, "dn_at_0");

    hold_up(60, "hold");
    release_btns("hold");

    do_reset("reset3");
    hold_up(35, "prehold");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state("rst_mid", 0, 0);
    rst = 1'b0;
    ma  = 1;
    mb  = 2;
    push_exp(DB + 3, 0, 0);
    push_exp(DB + 4, ma, mb);
    run_cycles(DB + 5, "post_rst");
    release_btns("post_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sat_updown_ctrl.md
SAT_UPDOWN_CTRL -- requirements
Module: sat_updown_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 3: counter width in bits.
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1: upper saturation limit, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter STEP, default 1: increment/decrement per accepted pulse, legal range 1..MAX_VAL.
REQ-004 SHALL have parameter DB_CYCLES, default 1000: consecutive stable clocks required to accept a button level.
REQ-005 SHALL have parameter RPT_DELAY, default 50000: hold clocks before auto-repeat starts.
REQ-006 SHALL have parameter RPT_PERIOD, default 10000: clocks between auto-repeat pulses.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-009 SHALL have ports btn_up and btn_dn, input, 1 each: raw asynchronous active-high buttons.
REQ-010 SHALL have port value, output, WIDTH: registered counter value.
REQ-011 SHALL have ports at_min and at_max, output, 1 each: registered flags, high when value==0 and value==MAX_VAL respectively.
REQ-012 SHALL have ports led_r and led_g, output, 1 each: led_r = at_max, led_g = at_min.

Function
REQ-013 SHALL pass each button through a 2-flop synchroniser before any other use.
REQ-014 SHALL update a button's debounced level only after the synchronised level differs from it for DB_CYCLES consecutive clocks; any bounce restarts the count.
REQ-015 SHALL emit a one-clock pulse on each debounced rising edge; a debounced falling edge emits nothing.
REQ-016 SHALL make value change exactly DB_CYCLES+3 clocks after the first clock edge at which a clean press is sampled high.
REQ-017 On an up pulse alone: value = min(value+STEP, MAX_VAL), computed in WIDTH+1 bits so no wrap occurs.
REQ-018 On a down pulse alone: value = value-STEP if value>=STEP, else 0; no wrap.
REQ-019 On simultaneous up and down pulses in the same clock: value unchanged.
REQ-020 SHALL update at_min/at_max in the same clock as value, so they always match the registered value.
REQ-021 Pulses at the saturated limit SHALL leave value and flags unchanged (no glitch).

Reset
REQ-022 While rst is high: value=0, at_min=1, at_max=0, led_g=1, led_r=0; synchronisers, debounced levels and debounce counters cleared to 0; repeat FSMs to IDLE.
REQ-023 Reset asserted mid-press or mid-repeat SHALL abort it; after release, a button still held SHALL be re-debounced from zero and counted as a fresh press.

Configuration
REQ-024 Macro SAT_AUTOREPEAT_EN defined: each button SHALL have an FSM with states IDLE, HOLD, REPEAT.
 - IDLE -> HOLD on a debounced rise; that rise emits the first pulse.
 - HOLD -> REPEAT after RPT_DELAY clocks held; emits a pulse on entry.
 - REPEAT emits a pulse every RPT_PERIOD clocks.
 - HOLD or REPEAT -> IDLE on debounced release.
REQ-025 Macro not defined: no FSM and no repeat timers; exactly one pulse per debounced press.

Structure
REQ-026 Shared package sat_ctrl_pkg SHALL hold the repeat FSM state typedef (IDLE/HOLD/REPEAT) and the default parameter constants.
REQ-027 Synchroniser, debounce, edge detection and repeat FSM SHALL live in sub-module btn_conditioner, instantiated once per button; sat_updown_ctrl holds the arithmetic and flags.

Verification (WIDTH=3, MAX_VAL=7, STEP=1, DB_CYCLES=4, RPT_DELAY=20, RPT_PERIOD=5)
REQ-028 Reset, then 8 clean up presses -> value 1..7 then holds at 7; at_max=led_r=1 after the 7th press; value=7 after the 8th.
REQ-029 Up press with bounce (high 2, low 1, high 10 clocks) -> exactly one increment, 7 clocks after the final rising sample.
REQ-030 value=3, up and down pressed in the same clock -> value stays 3; value=0 with STEP=2, down press -> value 0, at_min=1.
REQ-031 SAT_AUTOREPEAT_EN defined, up held 60 clocks from value 0 -> first increment at debounce, second 20 clocks later, then one every 5 clocks until saturation at 7.
REQ-032 rst pulsed for 1 clock during an active repeat with up still held -> value=0, at_min=1, then a fresh increment DB_CYCLES+3 clocks after rst falls.
